serial_out: RTL and testbench
=============================

// Module: serial_out
// PURPOSE
//   UART transmitter inside sys: CPU I/O port writes bytes, block serialises them onto TXD.
//   Directly upstream of serial_in: the sim receiver decodes its frames for the console.
//   8N1 framing, LSB first, fixed cycles-per-bit divider, small byte FIFO so
//   back-to-back port writes do not stall the CPU.
// PARAMETERS
//   CLK_DIV     16  m_clock cycles per serial bit (>=2); must match serial_in divider
//   FIFO_DEPTH  4   byte FIFO entries, power of two (2..16)
// PORTS
//   m_clock     in   1  system clock, all state on rising edge
//   p_reset     in   1  reset, synchronous, active-high
//   port_write  in   1  CPU write strobe, one byte per asserted cycle
//   data        in   8  byte to transmit, sampled with port_write
//   txready     out  1  1 = FIFO not full, write will be accepted
//   txd         out  1  serial line, idle high, registered
//   busy        out  1  1 = frame in progress or FIFO non-empty
//   done        out  1  one-cycle pulse in last cycle of each stop bit
// BEHAVIOUR
//   Reset values: txd=1, txready=1, busy=0, done=0; FIFO empty; FSM IDLE; counters 0.
//   Accept: port_write & txready at edge N -> byte enqueued. Write with txready=0 dropped.
//   txready from registered count; full + pop same cycle still refuses the write.
//   FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE or START.
//     IDLE: FIFO non-empty -> pop into shift reg, go START.
//     Each bit held exactly CLK_DIV cycles (bit counter 0..CLK_DIV-1, wraps at terminal).
//     STOP end: done=1 that cycle; FIFO non-empty -> START directly, no idle gap.
//   Latency: byte accepted at edge N into empty FIFO, FSM IDLE -> txd low from edge N+2.
//   Frame = 10*CLK_DIV cycles (11*CLK_DIV with parity).
//   Simultaneous write+pop when not full: both take effect, count unchanged.
//   Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
//   Reset mid-frame: next edge txd=1, FIFO flushed, frame abandoned, no done pulse.
// CONFIGURATION
//   SERIAL_OUT_PARITY_EN defined: PARITY state between DATA and STOP sends even
//     parity (XOR of 8 data bits) for CLK_DIV cycles; 8E1 framing.
//   Undefined: no PARITY state, 8N1 framing, parity logic absent.
// STRUCTURE
//   Shared package: FSM state encoding (IDLE, START, DATA, PARITY, STOP),
//     DATA_W=8, STOP_BITS=1 constants.
//   Sub-module serial_fifo: synchronous byte FIFO (push, pop, dout, full, empty, count);
//     serial_out holds FSM, bit-rate counter, shift register, parity.
// TESTING
//   CLK_DIV=16, write 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 16 cycles;
//     start at N+2, done at N+161, busy low after.
//   Loopback: txd into serial_in, write 0x41 -> receiver data=0x41, done pulses once.
//   5 writes 0x10..0x14 in 5 cycles -> txready low after 4th, 0x14 dropped;
//     0x10..0x13 sent back-to-back, no gap.
//   p_reset during DATA of 0xA3 with 2 bytes queued -> txd=1 next edge,
//     busy=0, no done pulse, nothing sent after release.
//   Full FIFO, write during pop cycle -> write refused, count stays DEPTH-1.
//   SERIAL_OUT_PARITY_EN, write 0x07 -> parity bit 1; write 0x03 -> parity bit 0;
//     frame 176 cycles.

Source files
------------

// File: rtl/serial_out_pkg.sv
// Shared definitions for the serial_out UART transmitter: frame constants,
// transmitter FSM state encoding and the parity helper.
package serial_out_pkg;

  // Payload bits per frame and stop bits per frame.
  localparam int DATA_W    = 8;
  localparam int STOP_BITS = 1;

  // Transmitter states. PARITY is only visited when parity framing is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_fifo.sv
// Synchronous byte FIFO between the CPU write port and the transmitter.
// Power-of-two depth so pointers wrap by plain overflow; count is one bit
// wider than the pointers so that full and empty are distinguishable.
module serial_fifo
  import serial_out_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       din,
  input  logic                    pop,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Status comes straight from the registered count, so a pop in the same
  // cycle never frees a slot for a write arriving while full.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/serial_out.sv
// UART transmitter: CPU port writes land in a small FIFO, and the FSM
// serialises each byte onto txd as start bit, 8 data bits LSB first and
// one stop bit, each bit held CLK_DIV clocks. Frames run back to back
// while the FIFO holds data.
// Optional feature: define SERIAL_OUT_PARITY_EN to insert an even parity
// bit between the data bits and the stop bit (8E1 instead of 8N1).
module serial_out
  import serial_out_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              port_write,
  input  logic [DATA_W-1:0] data,
  output logic              txready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  tx_state_e         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [FCNT_W-1:0] fifo_count;

  logic              bit_end;
  logic              stop_end;
  logic              load;
  logic              line_bit;

  serial_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (m_clock),
    .rst   (p_reset),
    .push  (port_write),
    .din   (data),
    .pop   (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A bit period ends when the rate counter reaches its terminal value;
  // the frame ends at the close of the last stop bit.
  assign bit_end  = (bit_cnt == CNT_LAST);
  assign stop_end = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);

  // Next byte is taken from the FIFO either from idle or straight out of
  // the stop bit, which is what keeps consecutive frames gapless.
  assign load    = !fifo_empty && ((state == ST_IDLE) || stop_end);
  assign txready = !fifo_full;

`ifdef SERIAL_OUT_PARITY_EN
  logic par_bit;

  // Parity is computed once per byte as it leaves the FIFO.
  always_ff @(posedge m_clock) begin
    if (load) par_bit <= even_parity(fifo_dout);
  end
`endif

  // Line level for the current state; registered into txd one clock later.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shreg[0];
`ifdef SERIAL_OUT_PARITY_EN
      ST_PARITY: line_bit = par_bit;
`endif
      default:   line_bit = 1'b1;
    endcase
  end

  // Shift register: loaded on pop, shifted right at the end of each data bit.
  always_ff @(posedge m_clock) begin
    if (load) begin
      shreg <= fifo_dout;
    end else if ((state == ST_DATA) && bit_end) begin
      shreg <= {1'b0, shreg[DATA_W-1:1]};
    end
  end

  // Framing FSM, bit-rate counter and registered line/status outputs.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      txd  <= line_bit;
      done <= stop_end;
      busy <= (state != ST_IDLE) || (fifo_count != '0);

      if ((state == ST_IDLE) || bit_end) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_ONE;
      end

      case (state)
        ST_IDLE: begin
          bit_idx <= '0;
          if (load) state <= ST_START;
        end
        ST_START: begin
          if (bit_end) begin
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
`ifdef SERIAL_OUT_PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
            end
          end
        end
`ifdef SERIAL_OUT_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            bit_idx <= '0;
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= load ? ST_START : ST_IDLE;
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
            end
          end
        end
        default: begin
          bit_idx <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_out.sv
// Bench for serial_out: randomized and directed port writes, a transaction
// level model of the FIFO and frame timing, and a line monitor that decodes
// txd frames and checks them against a queue of expected bytes.
module tb_serial_out;

  localparam int CD    = 16;
  localparam int DEPTH = 4;
`ifdef SERIAL_OUT_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CD;

  logic       clk        = 1'b0;
  logic       p_reset    = 1'b1;
  logic       port_write = 1'b0;
  logic [7:0] data       = 8'h00;
  logic       txready;
  logic       txd;
  logic       busy;
  logic       done;

  serial_out #(
    .CLK_DIV    (CD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .m_clock    (clk),
    .p_reset    (p_reset),
    .port_write (port_write),
    .data       (data),
    .txready    (txready),
    .txd        (txd),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  exp_t       exp_q[$];   // frames expected on the line: byte and first low cycle
  logic [7:0] mq[$];      // model of FIFO contents
  int         cyc       = 0;
  bit         m_active  = 1'b0;
  int         m_end     = 0;
  bit         last_rst  = 1'b0;
  bit         e_txready = 1'b1;
  bit         e_busy    = 1'b0;
  bit         e_done    = 1'b0;
  bit         mon_en    = 1'b0;
  int         n_checks  = 0;
  int         n_pass    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction model of one clock edge: FIFO occupancy as a queue, each
  // frame occupying FRAME edges after the edge that takes its byte.
  task automatic model_step(input bit rst, input bit pw, input logic [7:0] din);
    int         cnt_pre;
    bit         pop;
    bit         accept;
    logic [7:0] b;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_active  = 1'b0;
      e_txready = 1'b1;
      e_busy    = 1'b0;
      e_done    = 1'b0;
      last_rst  = 1'b1;
    end else begin
      last_rst = 1'b0;
      cnt_pre  = mq.size();
      e_busy   = m_active || (cnt_pre > 0);
      e_done   = m_active && (cyc == m_end);
      accept   = pw && (cnt_pre < DEPTH);
      pop      = 1'b0;
      if (!m_active && cnt_pre > 0) pop = 1'b1;
      else if (m_active && cyc == m_end) begin
        if (cnt_pre > 0) pop = 1'b1;
        else m_active = 1'b0;
      end
      if (pop) begin
        b = mq.pop_front();
        exp_q.push_back('{b: b, t: cyc + 1});
        m_active = 1'b1;
        m_end    = cyc + FRAME;
      end
      if (accept) mq.push_back(din);
      e_txready = (mq.size() < DEPTH);
    end
  endtask

  task automatic step(input bit rst, input bit pw, input logic [7:0] din);
    p_reset    = rst;
    port_write = pw;
    data       = din;
    @(posedge clk);
    cyc++;
    model_step(rst, pw, din);
    #1;
    chk("txready", txready, e_txready);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    if (rst) chk("txd_after_reset", txd, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_active || mq.size() != 0 || exp_q.size() != 0) && n < 20 * FRAME) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk("drain_timeout", (m_active || mq.size() != 0 || exp_q.size() != 0), 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  // Line monitor: finds a start bit, samples each bit mid-period, and
  // compares the decoded frame with the next expected one.
  initial begin
    bit          rx = 1'b0;
    int          s  = 0;
    logic [10:0] fr = '1;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (last_rst) begin
          rx = 1'b0;
        end else begin
          if (!rx && txd === 1'b0) begin
            rx = 1'b1;
            s  = cyc;
            fr = '1;
          end
          if (rx) begin
            for (int k = 0; k < NBITS; k++)
              if (cyc == s + k * CD + CD / 2) fr[k] = txd;
            if (cyc == s + FRAME - 1) begin
              rx = 1'b0;
              if (exp_q.size() == 0) begin
                chk("spurious_frame", 1'b1, 1'b0);
              end else begin
                e = exp_q.pop_front();
                chk("frame_data", fr[8:1], e.b);
                chk("frame_start", s, e.t);
                chk("start_bit", fr[0], 1'b0);
                chk("stop_bit", fr[NBITS-1], 1'b1);
`ifdef SERIAL_OUT_PARITY_EN
                chk("parity_bit", fr[9], ^e.b);
`endif
              end
            end
          end
        end
      end
    end
  end

  initial begin
    bit pw;
    bit rst;
    repeat (3) step(1'b1, 1'b0, 8'h00);
    mon_en = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);

    // Single bytes from idle.
    step(1'b0, 1'b1, 8'h55);
    repeat (FRAME + 10) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h41);
    repeat (FRAME + 10) step(1'b0, 1'b0, 8'h00);

    // Burst while a frame is in flight, then writes held across pop cycles.
    step(1'b0, 1'b1, 8'hAA);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b1, 8'($urandom));
    drain();

    // Reset in the middle of a frame with bytes still queued.
    step(1'b0, 1'b1, 8'hA3);
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 8'hC3);
    repeat (4 * CD) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    repeat (2 * FRAME) step(1'b0, 1'b0, 8'h00);

    // Odd and even popcount bytes.
    step(1'b0, 1'b1, 8'h07);
    step(1'b0, 1'b1, 8'h03);
    drain();

    // Random traffic with occasional resets.
    for (int i = 0; i < 6000; i++) begin
      pw  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 2999) == 0);
      step(rst, pw, 8'($urandom));
    end
    drain();

    chk("queues_empty", exp_q.size() + mq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
